// File: rtl/spcpu_prefetch_unit_pkg.sv
// Shared types and constants for the spcpu instruction prefetch unit.
package pkg_prefetch;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_DISCARD
    } fetch_state_t;

    localparam int HW_BYTES   = 2;
    localparam int WORD_BYTES = 4;

    // Width of an occupancy counter that must represent 0..depth inclusive.
    function automatic int count_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/spcpu_prefetch_unit_fifo.sv
// Halfword circular buffer feeding the instruction decode; pops up to two entries per cycle.
module prefetch_hw_fifo
    import pkg_prefetch::*;
#(
    parameter int WORD_WIDTH = 16,
    parameter int DEPTH      = 4,
    localparam int CW        = count_width(DEPTH),
    localparam int PW        = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic [WORD_WIDTH-1:0] push_data,
    input  logic [1:0]            pop_cnt,
    input  logic                  flush,
    output logic [WORD_WIDTH-1:0] head0,
    output logic [WORD_WIDTH-1:0] head1,
    output logic [CW-1:0]         count
);

    logic [WORD_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]         rd_ptr;
    logic [PW-1:0]         wr_ptr;

    // Pointer advance modulo DEPTH, which need not be a power of two.
    function automatic logic [PW-1:0] ptr_add(input logic [PW-1:0] p, input logic [1:0] n);
        int s;
        s = int'(p) + int'(n);
        if (s >= DEPTH) s = s - DEPTH;
        return PW'(s);
    endfunction

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= ptr_add(wr_ptr, 2'd1);
            rd_ptr <= ptr_add(rd_ptr, pop_cnt);
            count  <= count + CW'(push) - CW'(pop_cnt);
        end
    end

    // NOTE: storage is deliberately not reset; count gates every use of its contents.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    assign head0 = mem[rd_ptr];
    assign head1 = mem[ptr_add(rd_ptr, 2'd1)];

endmodule

// File: rtl/spcpu_prefetch_unit.sv
// Decoupled instruction fetch front end: request/ack memory port in, 16/32-bit instructions out.
module spcpu_prefetch_unit
    import pkg_prefetch::*;
#(
    parameter int                    ADDR_WIDTH = 16,
    parameter int                    WORD_WIDTH = 16,
    parameter int                    DEPTH      = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
    parameter logic [WORD_WIDTH-1:0] LONG_MASK  = 16'hf000,
    parameter logic [WORD_WIDTH-1:0] LONG_MATCH = 16'hf000
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic                  mem_req,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic                  mem_ack,
    input  logic [WORD_WIDTH-1:0] mem_rdata,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    output logic [WORD_WIDTH-1:0] instr_hi,
    output logic [WORD_WIDTH-1:0] instr_lo,
    output logic                  instr_is_32,
    output logic [ADDR_WIDTH-1:0] instr_pc,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc
);

    localparam int CW = count_width(DEPTH);

    fetch_state_t          state, state_next;
    logic [ADDR_WIDTH-1:0] fetch_pc, fetch_pc_next;
    logic [ADDR_WIDTH-1:0] instr_pc_next, mem_addr_next;
    logic [WORD_WIDTH-1:0] head0, head1;
    logic [CW-1:0]         count;
    logic [CW:0]           count_next;
    logic [1:0]            pop_cnt;
    logic                  push, consume, has_space;

    prefetch_hw_fifo #(
        .WORD_WIDTH(WORD_WIDTH),
        .DEPTH     (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (push),
        .push_data(mem_rdata),
        .pop_cnt  (pop_cnt),
        .flush    (redirect_valid),
        .head0    (head0),
        .head1    (head1),
        .count    (count)
    );

    // NOTE: state and PC registers use non-blocking assignments; all next values come from the comb blocks.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            mem_req  <= 1'b0;
            mem_addr <= RESET_PC;
            fetch_pc <= RESET_PC;
            instr_pc <= RESET_PC;
        end else begin
            state    <= state_next;
            mem_req  <= (state_next != ST_IDLE);
            mem_addr <= mem_addr_next;
            fetch_pc <= fetch_pc_next;
            instr_pc <= instr_pc_next;
        end
    end

    // A request is only launched when the halfword it returns is sure to find a free slot.
    always_comb begin
        state_next    = state;
        fetch_pc_next = fetch_pc;
        instr_pc_next = instr_pc;
        mem_addr_next = mem_addr;
        if (consume)
            instr_pc_next = instr_pc + (instr_is_32 ? ADDR_WIDTH'(WORD_BYTES) : ADDR_WIDTH'(HW_BYTES));
        unique case (state)
            ST_IDLE: begin
                if (!redirect_valid && has_space) begin
                    state_next    = ST_REQ;
                    mem_addr_next = fetch_pc;
                end
            end
            ST_REQ: begin
                if (redirect_valid) begin
                    state_next = mem_ack ? ST_IDLE : ST_DISCARD;
                end else if (mem_ack) begin
                    fetch_pc_next = fetch_pc + ADDR_WIDTH'(HW_BYTES);
                    if (has_space) mem_addr_next = fetch_pc_next;
                    else           state_next    = ST_IDLE;
                end
            end
            ST_DISCARD: begin
                if (mem_ack) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
        if (redirect_valid) begin
            fetch_pc_next = redirect_pc & ~ADDR_WIDTH'(1);
            instr_pc_next = redirect_pc & ~ADDR_WIDTH'(1);
        end
    end

    always_comb begin
        instr_is_32 = ((head0 & LONG_MASK) == LONG_MATCH);
        instr_valid = ((count != '0) && !instr_is_32) || (count >= CW'(2));
        instr_hi    = head0;
        instr_lo    = instr_is_32 ? head1 : '0;
        consume     = instr_valid && instr_ready && !redirect_valid;
        pop_cnt     = 2'd0;
        if (consume) pop_cnt = instr_is_32 ? 2'd2 : 2'd1;
        push        = (state == ST_REQ) && mem_ack && !redirect_valid;
        count_next  = {1'b0, count} + (CW+1)'(push) - (CW+1)'(pop_cnt);
        has_space   = (count_next < (CW+1)'(DEPTH));
    end

endmodule

// File: tb/tb_spcpu_prefetch_unit.sv
// Directed, table-driven bench for spcpu_prefetch_unit (RESET_PC=0x0100, DEPTH=4).
module tb_spcpu_prefetch_unit;

    typedef struct {
        logic        ack;
        logic [15:0] rdata;
        logic        ready;
        logic        redir;
        logic [15:0] rpc;
        logic        req;
        logic [15:0] addr;
        logic        valid;
        logic        is32;
        logic [15:0] hi;
        logic [15:0] lo;
        logic [15:0] pc;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack;
    logic [15:0] mem_rdata;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] instr_hi;
    logic [15:0] instr_lo;
    logic        instr_is_32;
    logic [15:0] instr_pc;
    logic        redirect_valid;
    logic [15:0] redirect_pc;

    int errors = 0;
    int checks = 0;
    vec_t vecs [34];

    always #5 clk = ~clk;

    spcpu_prefetch_unit #(
        .ADDR_WIDTH(16),
        .WORD_WIDTH(16),
        .DEPTH     (4),
        .RESET_PC  (16'h0100),
        .LONG_MASK (16'hf000),
        .LONG_MATCH(16'hf000)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .mem_req       (mem_req),
        .mem_addr      (mem_addr),
        .mem_ack       (mem_ack),
        .mem_rdata     (mem_rdata),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .instr_hi      (instr_hi),
        .instr_lo      (instr_lo),
        .instr_is_32   (instr_is_32),
        .instr_pc      (instr_pc),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t v(input logic ack, input logic [15:0] rdata, input logic ready,
                               input logic redir, input logic [15:0] rpc, input logic req,
                               input logic [15:0] addr, input logic valid, input logic is32,
                               input logic [15:0] hi, input logic [15:0] lo, input logic [15:0] pc);
        vec_t r;
        r = '{ack, rdata, ready, redir, rpc, req, addr, valid, is32, hi, lo, pc};
        return r;
    endfunction

    task automatic drive(input logic ack, input logic [15:0] rdata, input logic ready,
                         input logic redir, input logic [15:0] rpc);
        mem_ack        = ack;
        mem_rdata      = rdata;
        instr_ready    = ready;
        redirect_valid = redir;
        redirect_pc    = rpc;
    endtask

    task automatic check_outputs(input string tag, input vec_t e);
        check({tag, " mem_req"},     32'(mem_req),     32'(e.req));
        check({tag, " mem_addr"},    32'(mem_addr),    32'(e.addr));
        check({tag, " instr_valid"}, 32'(instr_valid), 32'(e.valid));
        check({tag, " instr_pc"},    32'(instr_pc),    32'(e.pc));
        if (e.valid) begin
            check({tag, " instr_is_32"}, 32'(instr_is_32), 32'(e.is32));
            check({tag, " instr_hi"},    32'(instr_hi),    32'(e.hi));
            check({tag, " instr_lo"},    32'(instr_lo),    32'(e.lo));
        end
    endtask

    initial begin
        //            ack rdata     rdy redir rpc       req addr      val i32 hi        lo        pc
        vecs[0]  = v(0, 16'h0000, 1, 0, 16'h0000, 0, 16'h0100, 0, 0, 16'h0000, 16'h0000, 16'h0100);
        vecs[1]  = v(0, 16'h0000, 1, 0, 16'h0000, 1, 16'h0100, 0, 0, 16'h0000, 16'h0000, 16'h0100);
        vecs[2]  = v(1, 16'h1234, 1, 0, 16'h0000, 1, 16'h0100, 0, 0, 16'h0000, 16'h0000, 16'h0100);
        vecs[3]  = v(1, 16'h5678, 1, 0, 16'h0000, 1, 16'h0102, 1, 0, 16'h1234, 16'h0000, 16'h0100);
        vecs[4]  = v(1, 16'hF00A, 1, 0, 16'h0000, 1, 16'h0104, 1, 0, 16'h5678, 16'h0000, 16'h0102);
        vecs[5]  = v(0, 16'h0000, 1, 0, 16'h0000, 1, 16'h0106, 0, 0, 16'h0000, 16'h0000, 16'h0104);
        vecs[6]  = v(1, 16'hBEEF, 1, 0, 16'h0000, 1, 16'h0106, 0, 0, 16'h0000, 16'h0000, 16'h0104);
        vecs[7]  = v(0, 16'h0000, 1, 0, 16'h0000, 1, 16'h0108, 1, 1, 16'hF00A, 16'hBEEF, 16'h0104);
        vecs[8]  = v(1, 16'h1111, 0, 0, 16'h0000, 1, 16'h0108, 0, 0, 16'h0000, 16'h0000, 16'h0108);
        vecs[9]  = v(1, 16'h2222, 0, 0, 16'h0000, 1, 16'h010A, 1, 0, 16'h1111, 16'h0000, 16'h0108);
        vecs[10] = v(1, 16'h3333, 0, 0, 16'h0000, 1, 16'h010C, 1, 0, 16'h1111, 16'h0000, 16'h0108);
        vecs[11] = v(1, 16'h4444, 0, 0, 16'h0000, 1, 16'h010E, 1, 0, 16'h1111, 16'h0000, 16'h0108);
        vecs[12] = v(0, 16'h0000, 0, 0, 16'h0000, 0, 16'h010E, 1, 0, 16'h1111, 16'h0000, 16'h0108);
        vecs[13] = v(1, 16'h9999, 0, 0, 16'h0000, 0, 16'h010E, 1, 0, 16'h1111, 16'h0000, 16'h0108);
        vecs[14] = v(0, 16'h0000, 1, 0, 16'h0000, 0, 16'h010E, 1, 0, 16'h1111, 16'h0000, 16'h0108);
        vecs[15] = v(1, 16'h5555, 0, 0, 16'h0000, 1, 16'h0110, 1, 0, 16'h2222, 16'h0000, 16'h010A);
        vecs[16] = v(0, 16'h0000, 0, 0, 16'h0000, 0, 16'h0110, 1, 0, 16'h2222, 16'h0000, 16'h010A);
        vecs[17] = v(0, 16'h0000, 1, 0, 16'h0000, 0, 16'h0110, 1, 0, 16'h2222, 16'h0000, 16'h010A);
        vecs[18] = v(0, 16'h0000, 1, 1, 16'h0201, 1, 16'h0112, 1, 0, 16'h3333, 16'h0000, 16'h010C);
        vecs[19] = v(0, 16'h0000, 0, 0, 16'h0000, 1, 16'h0112, 0, 0, 16'h0000, 16'h0000, 16'h0200);
        vecs[20] = v(0, 16'h0000, 0, 0, 16'h0000, 1, 16'h0112, 0, 0, 16'h0000, 16'h0000, 16'h0200);
        vecs[21] = v(1, 16'hDEAD, 0, 0, 16'h0000, 1, 16'h0112, 0, 0, 16'h0000, 16'h0000, 16'h0200);
        vecs[22] = v(0, 16'h0000, 0, 0, 16'h0000, 0, 16'h0112, 0, 0, 16'h0000, 16'h0000, 16'h0200);
        vecs[23] = v(1, 16'h0777, 0, 0, 16'h0000, 1, 16'h0200, 0, 0, 16'h0000, 16'h0000, 16'h0200);
        vecs[24] = v(1, 16'h8888, 1, 1, 16'hFFFF, 1, 16'h0202, 1, 0, 16'h0777, 16'h0000, 16'h0200);
        vecs[25] = v(0, 16'h0000, 0, 0, 16'h0000, 0, 16'h0202, 0, 0, 16'h0000, 16'h0000, 16'hFFFE);
        vecs[26] = v(1, 16'hF001, 0, 0, 16'h0000, 1, 16'hFFFE, 0, 0, 16'h0000, 16'h0000, 16'hFFFE);
        vecs[27] = v(1, 16'h0042, 0, 0, 16'h0000, 1, 16'h0000, 0, 0, 16'h0000, 16'h0000, 16'hFFFE);
        vecs[28] = v(0, 16'h0000, 1, 0, 16'h0000, 1, 16'h0002, 1, 1, 16'hF001, 16'h0042, 16'hFFFE);
        vecs[29] = v(0, 16'h0000, 0, 1, 16'h0300, 1, 16'h0002, 0, 0, 16'h0000, 16'h0000, 16'h0002);
        vecs[30] = v(0, 16'h0000, 0, 1, 16'h0400, 1, 16'h0002, 0, 0, 16'h0000, 16'h0000, 16'h0300);
        vecs[31] = v(1, 16'h0001, 0, 0, 16'h0000, 1, 16'h0002, 0, 0, 16'h0000, 16'h0000, 16'h0400);
        vecs[32] = v(0, 16'h0000, 0, 0, 16'h0000, 0, 16'h0002, 0, 0, 16'h0000, 16'h0000, 16'h0400);
        vecs[33] = v(0, 16'h0000, 0, 0, 16'h0000, 1, 16'h0400, 0, 0, 16'h0000, 16'h0000, 16'h0400);

        reset = 1'b1;
        drive(0, 16'h0000, 0, 0, 16'h0000);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // One vector per cycle: inputs are applied and outputs sampled mid-cycle, then the edge advances.
        for (int i = 0; i < 34; i++) begin
            if (i > 0) @(negedge clk);
            drive(vecs[i].ack, vecs[i].rdata, vecs[i].ready, vecs[i].redir, vecs[i].rpc);
            #1;
            check_outputs($sformatf("vec%0d", i), vecs[i]);
        end

        // Reset while a request is pending, with an ack in the reset cycle that must be ignored.
        @(negedge clk);
        reset = 1'b1;
        drive(1, 16'hABCD, 1, 0, 16'h0000);
        @(negedge clk);
        reset = 1'b0;
        drive(0, 16'h0000, 0, 0, 16'h0000);
        #1;
        check_outputs("rst0", v(0, 0, 0, 0, 0, 0, 16'h0100, 0, 0, 0, 0, 16'h0100));
        @(negedge clk);
        drive(1, 16'h4321, 0, 0, 16'h0000);
        #1;
        check_outputs("rst1", v(0, 0, 0, 0, 0, 1, 16'h0100, 0, 0, 0, 0, 16'h0100));
        @(negedge clk);
        drive(0, 16'h0000, 0, 0, 16'h0000);
        #1;
        check_outputs("rst2", v(0, 0, 0, 0, 0, 1, 16'h0102, 1, 0, 16'h4321, 16'h0000, 16'h0100));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
